// File: rtl/mul4_ctrl.sv
// rtl/mul4_ctrl.sv - 4x4 multiplier front-end for an external product ROM, with a FWFT result buffer
module mul4_ctrl #(
  parameter int ROM_LAT = 1,
  parameter int DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_a,
  input  logic [3:0]  in_b,
  output logic [7:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_prod,
  output logic [15:0] done_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = PW + 1;

  logic [OW-1:0]  occ;
  logic [OW-1:0]  count;
  logic [ROM_LAT:0] tag;
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic [7:0]     mem [DEPTH];

  logic in_xfer;
  logic out_xfer;
  logic wr_en;

  // occ reserves a buffer slot at accept time, so the FIFO can never overflow
  assign in_ready  = (occ < OW'(DEPTH));
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = (count != '0);
  assign out_xfer  = out_valid && out_ready;
  assign wr_en     = tag[ROM_LAT];
  assign out_prod  = out_valid ? mem[rptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_addr <= 8'h00;
      tag      <= '0;
      occ      <= '0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      done_cnt <= 16'h0000;
    end else begin
      if (in_xfer) begin
        rom_addr <= {in_a, in_b};
      end
      tag <= {tag[ROM_LAT-1:0], in_xfer};

      case ({in_xfer, out_xfer})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase

      case ({wr_en, out_xfer})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase

      if (wr_en) begin
        wptr <= wptr + PW'(1);
      end
      if (out_xfer) begin
        rptr     <= rptr + PW'(1);
        done_cnt <= done_cnt + 16'd1;
      end
    end
  end

  // Buffer storage needs no reset: count gates every read of it
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      mem[wptr] <= rom_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      assert (count < OW'(DEPTH));
    end
  end

endmodule

// File: tb/tb_mul4_ctrl.sv
// tb/tb_mul4_ctrl.sv - scoreboard bench for mul4_ctrl with a product ROM model
module tb_mul4_ctrl;

  localparam int ROM_LAT = 1;
  localparam int DEPTH   = 4;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic [7:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_prod;
  logic [15:0] done_cnt;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] rom_pipe [ROM_LAT];

  mul4_ctrl #(.ROM_LAT(ROM_LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_prod(out_prod),
    .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product ROM: addr[7:4]*addr[3:0], ROM_LAT edges from address to data
  always @(posedge clk) begin
    rom_pipe[0] <= {4'b0, rom_addr[7:4]} * {4'b0, rom_addr[3:0]};
    for (int i = 1; i < ROM_LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[ROM_LAT-1];

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [7:0] prod(logic [3:0] a, logic [3:0] b);
    return {4'b0, a} * {4'b0, b};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one operand pair for one edge; expected product is queued only if it is taken
  task automatic try_op(input logic [3:0] a, input logic [3:0] b, input logic [7:0] e, output bit ok);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    ok = in_ready;
    if (ok) exp_q.push_back(e);
    tick();
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stale_out: got 0x%0h expected no output at %0t", out_prod, $time);
          end else begin
            check("out_prod", {24'b0, out_prod}, {24'b0, exp_q.pop_front()});
          end
        end
      end else begin
        check("idle_prod", {24'b0, out_prod}, 32'h0);
      end
    end
  end

  initial begin
    bit ok;
    int n;
    int iter;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_a = 4'h0; in_b = 4'h0;
    tick();
    tick();
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_out_prod", {24'b0, out_prod}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_done_cnt", {16'b0, done_cnt}, 32'h0);
    check("rst_rom_addr", {24'b0, rom_addr}, 32'h0);
    rst = 1'b0;

    // Single op, latency 2
    try_op(4'd3, 4'd5, 8'h0F, ok);
    check("single_accept", {31'b0, ok}, 32'h1);
    in_valid = 1'b0;
    check("single_rom_addr", {24'b0, rom_addr}, 32'h35);
    check("single_valid_n0", {31'b0, out_valid}, 32'h0);
    tick();
    check("single_valid_n1", {31'b0, out_valid}, 32'h0);
    tick();
    check("single_valid_n2", {31'b0, out_valid}, 32'h1);
    check("single_prod_n2", {24'b0, out_prod}, 32'h0F);
    out_ready = 1'b1;
    tick();
    check("single_done", {16'b0, done_cnt}, 32'h1);
    check("single_empty", {31'b0, out_valid}, 32'h0);

    // Streaming
    try_op(4'd15, 4'd15, 8'hE1, ok); check("stream_rdy0", {31'b0, ok}, 32'h1);
    try_op(4'd0,  4'd7,  8'h00, ok); check("stream_rdy1", {31'b0, ok}, 32'h1);
    try_op(4'd9,  4'd9,  8'h51, ok); check("stream_rdy2", {31'b0, ok}, 32'h1);
    try_op(4'd1,  4'd1,  8'h01, ok); check("stream_rdy3", {31'b0, ok}, 32'h1);
    in_valid = 1'b0;
    check("stream_v3", {31'b0, out_valid}, 32'h1);
    tick();
    check("stream_v4", {31'b0, out_valid}, 32'h1);
    tick();
    check("stream_v5", {31'b0, out_valid}, 32'h1);
    tick();
    check("stream_v6", {31'b0, out_valid}, 32'h0);
    check("stream_done", {16'b0, done_cnt}, 32'h5);

    // Backpressure
    out_ready = 1'b0;
    n = 0;
    for (int k = 0; k < 6; k++) begin
      try_op(4'(n + 2), 4'(n + 3), prod(4'(n + 2), 4'(n + 3)), ok);
      if (ok) n++;
    end
    in_valid = 1'b0;
    check("bp_accepts", n, 4);
    check("bp_in_ready_full", {31'b0, in_ready}, 32'h0);
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_after_pop", {31'b0, in_ready}, 32'h1);
    repeat (4) tick();
    check("bp_drained", {31'b0, out_valid}, 32'h0);
    check("bp_done", {16'b0, done_cnt}, 32'h9);

    // Simultaneous accept and pop at occ=3
    out_ready = 1'b0;
    try_op(4'd1, 4'd2, 8'h02, ok); check("sim_acc0", {31'b0, ok}, 32'h1);
    try_op(4'd2, 4'd2, 8'h04, ok); check("sim_acc1", {31'b0, ok}, 32'h1);
    try_op(4'd3, 4'd3, 8'h09, ok); check("sim_acc2", {31'b0, ok}, 32'h1);
    in_valid = 1'b0;
    repeat (3) tick();
    out_ready = 1'b1;
    try_op(4'd5, 4'd6, 8'h1E, ok); check("sim_acc3", {31'b0, ok}, 32'h1);
    out_ready = 1'b0;
    check("sim_in_ready", {31'b0, in_ready}, 32'h1);
    try_op(4'd7, 4'd7, 8'h31, ok); check("sim_acc4", {31'b0, ok}, 32'h1);
    in_valid = 1'b0;
    check("sim_occ_full", {31'b0, in_ready}, 32'h0);
    out_ready = 1'b1;
    repeat (6) tick();
    check("sim_done", {16'b0, done_cnt}, 32'd14);
    check("sim_drained", {31'b0, out_valid}, 32'h0);

    // Reset with one result buffered and two in flight
    out_ready = 1'b0;
    try_op(4'd2,  4'd7,  8'h0E, ok);
    try_op(4'd3,  4'd9,  8'h1B, ok);
    try_op(4'd12, 4'd13, 8'h9C, ok);
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    exp_q.delete();
    check("mrst_out_valid", {31'b0, out_valid}, 32'h0);
    check("mrst_out_prod", {24'b0, out_prod}, 32'h0);
    check("mrst_in_ready", {31'b0, in_ready}, 32'h1);
    check("mrst_done_cnt", {16'b0, done_cnt}, 32'h0);
    check("mrst_rom_addr", {24'b0, rom_addr}, 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("mrst_no_stale", {31'b0, out_valid}, 32'h0);
    end

    // done_cnt wrap: 65535 pops to reach 0xFFFF, then one more
    n = 0;
    iter = 0;
    while (n < 65535 && iter < 70000) begin
      try_op(4'(n >> 4), 4'(n), prod(4'(n >> 4), 4'(n)), ok);
      if (ok) n++;
      iter++;
    end
    in_valid = 1'b0;
    check("wrap_accepts", n, 65535);
    repeat (4) tick();
    check("wrap_ffff", {16'b0, done_cnt}, 32'hFFFF);
    try_op(4'd15, 4'd14, 8'hD2, ok);
    in_valid = 1'b0;
    repeat (4) tick();
    check("wrap_zero", {16'b0, done_cnt}, 32'h0);
    check("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
